// File: rtl/wb_port_arbiter.sv
// Shares the integer register-file write port between the in-order writeback
// stage (priority) and a queued long-latency-unit result stream.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        llu_valid,
    output logic        llu_ready,
    input  logic [4:0]  llu_rd,
    input  logic [31:0] llu_wdata,
    output logic        rf_wen,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic [31:0] rd_pending
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;

    logic        empty, full, pipe_real, forced, push, pop;
    logic [36:0] head;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pipe_real = pipe_wen && (pipe_rd != 5'd0);
    assign forced    = !empty && (starve_q == SW'(STARVE_LIMIT));
    assign pop       = forced || (!pipe_real && !empty);
    assign head      = mem[rd_ptr_q];

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign llu_ready = rst_n && !full;
    assign push      = llu_valid && llu_ready && (llu_rd != 5'd0);

    always_comb begin
        rf_wen     = 1'b0;
        rf_rd      = 5'd0;
        rf_wdata   = 32'd0;
        pipe_stall = 1'b0;
        if (rst_n) begin
            if (forced) begin
                rf_wen     = 1'b1;
                rf_rd      = head[36:32];
                rf_wdata   = head[31:0];
                pipe_stall = 1'b1;
            end else if (pipe_real) begin
                rf_wen   = 1'b1;
                rf_rd    = pipe_rd;
                rf_wdata = pipe_wdata;
            end else if (!empty) begin
                rf_wen   = 1'b1;
                rf_rd    = head[36:32];
                rf_wdata = head[31:0];
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        starve_d = starve_q;
        if (empty || pop)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= {llu_rd, llu_wdata};
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    logic [31:0] entry_mask [DEPTH];
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
        logic [AW-1:0] offset;
        assign offset         = AW'(gi) - rd_ptr_q;
        assign entry_mask[gi] = ({1'b0, offset} < count_q) ? (32'd1 << mem[gi][36:32]) : 32'd0;
    end

    always_comb begin
        rd_pending = 32'd0;
        for (int i = 0; i < DEPTH; i++)
            rd_pending = rd_pending | entry_mask[i];
        rd_pending[0] = 1'b0;
    end
endmodule
